serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built around one instance of the 1-bit full adder (fa) plus a carry flip-flop.
//  Sits directly around the full-adder stage: feeds it one operand bit pair per clock and consumes sum/carry into shift registers.
//  Used as the low-area add path of the ALU; trades WIDTH cycles of latency for a single fa cell.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=2)
// PORTS
//  clk       in   1      clock, all state updates on rising edge
//  reset_n   in   1      asynchronous reset, active low
//  start     in   1      request: sample a, b, cin and begin an addition
//  a         in   WIDTH  operand A (sampled only on accepted start)
//  b         in   WIDTH  operand B (sampled only on accepted start)
//  cin       in   1      carry in (sampled only on accepted start)
//  busy      out  1      1 while an addition is in progress
//  done      out  1      one-cycle pulse: sum/cout/overflow valid
//  sum       out  WIDTH  result, held stable from done until next accepted start
//  cout      out  1      carry out of MSB, held like sum
//  overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB, held like sum
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0, counter=0, carry FF=0.
//  FSM states: IDLE, SHIFT, DONE.
//   IDLE : start=1 -> load a_sr=a, b_sr=b, carry=cin, cnt=0, go SHIFT. start=0 -> stay.
//   SHIFT: busy=1. Each cycle fa gets (a_sr[0], b_sr[0], carry); fa sum shifted into sum_sr MSB (shift right);
//          carry<=fa carry; a_sr, b_sr shift right; cnt++. On cycle with cnt==WIDTH-1 record carry-into-MSB
//          (current carry) for overflow, then go DONE. cnt width = clog2(WIDTH), wraps never observed.
//   DONE : done=1 for exactly this cycle; sum<=sum_sr, cout<=carry, overflow<=cMSB^carry registered on entry.
//          start=1 here is accepted (back-to-back) -> SHIFT; else -> IDLE.
//  Latency: start sampled at edge N -> done high in cycle after edge N+WIDTH (WIDTH+1 edges start-to-done).
//  start while busy=1 is ignored; operands are not re-sampled; no error flagged.
//  Result arithmetic is modulo 2^WIDTH; cout is the WIDTH+1'th bit.
//  sum/cout/overflow keep last result through IDLE and while the next op is in SHIFT; update only at DONE.
//  Reset asserted mid-SHIFT: immediate return to IDLE with all outputs at reset values; partial result discarded.
//  a/b/cin changes outside an accepted start have no effect.
// CONFIGURATION
//  SERIAL_ADDER_SUB_EN defined: extra input port sub (1 bit, sampled with start). sub=1 loads b_sr=~b and
//   carry=1 (cin ignored) -> sum = a - b mod 2^WIDTH, cout=1 means no borrow; overflow per signed subtraction.
//   sub=0 identical to the undefined build.
//  SERIAL_ADDER_SUB_EN undefined: no sub port; addition only, cin always used.
// TESTING (WIDTH=8, period 20 ns)
//  1) reset_n=0 then 1 -> busy=0 done=0 sum=8'h00 cout=0 overflow=0 before any start.
//  2) a=8'h0F b=8'h01 cin=0 start 1 cycle -> busy 8 cycles, done pulse 9 edges after start, sum=8'h10 cout=0 ovf=0.
//  3) a=8'hFF b=8'h01 cin=0 -> sum=8'h00 cout=1 ovf=0; a=8'h7F b=8'h01 cin=0 -> sum=8'h80 cout=0 ovf=1;
//     a=8'hFF b=8'hFF cin=1 -> sum=8'hFF cout=1 ovf=0.
//  4) start a=8'h03 b=8'h04; pulse start again 3 cycles later with a=8'hAA -> ignored, result sum=8'h07;
//     start held in DONE cycle with a=8'h10 b=8'h20 -> next done gives sum=8'h30 with no IDLE gap.
//  5) start a=8'h55 b=8'h55, drop reset_n after 4 SHIFT cycles -> busy=0 sum=8'h00 immediately, no done pulse;
//     after release, a=8'h01 b=8'h01 -> sum=8'h02.
//  6) SERIAL_ADDER_SUB_EN: sub=1 a=8'h05 b=8'h07 -> sum=8'hFE cout=0 ovf=0; sub=1 a=8'h80 b=8'h01 -> sum=8'h7F cout=1 ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder around one fa cell; define SERIAL_ADDER_SUB_EN to add a sub port for a - b
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, b_ld, sum_nx;
  logic [WIDTH-2:0] sum_sr;
  logic [CW-1:0] cnt;
  logic carry, c_ld, fa_s, fa_c, accept, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif
  fa u_fa (.a(a_sr[0]), .b(b_sr[0]), .ci(carry), .s(fa_s), .co(fa_c));
  assign busy   = state == SHIFT;
  assign done   = state == DONE;
  assign accept = start && !busy;
  assign last   = busy && cnt == CW'(WIDTH - 1);
  assign sum_nx = {fa_s, sum_sr};
  always_comb begin
    nxt = busy ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      sum_sr   <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_sr  <= a;
        b_sr  <= b_ld;
        carry <= c_ld;
        cnt   <= '0;
      end else if (busy) begin
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= sum_nx[WIDTH-1:1];
        carry  <= fa_c;
        cnt    <= cnt + 1'b1;
        // carry still holds the carry into the MSB on the final shift
        if (last) begin
          sum      <= sum_nx;
          cout     <= fa_c;
          overflow <= carry ^ fa_c;
        end
      end
    end
  end
endmodule
